// File: rtl/data_bus_pkg.sv
// data_bus_pkg: shared types for the data-bus to memory bridge.
// Holds the transfer size encodings, the byte-enable decoder, the request
// queue entry, the slave configuration record and the head FSM states.
package data_bus_pkg;

  typedef logic [31:0] base_addr_type;
  typedef logic [31:0] addr_mask_type;

  localparam base_addr_type CFG_BADR_MEM = 32'h0000_0000;
  localparam addr_mask_type CFG_MADR_MEM = 32'hFFFF_0000;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef struct packed {
    base_addr_type base_addr;
    addr_mask_type addr_mask;
  } db_conf_t;

  typedef struct packed {
    logic [1:0] size;
    logic [1:0] lsb;
    logic       illegal;
  } be_dec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [1:0]  lsb;
    logic        illegal;
  } db_req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } head_st_e;

  // Only naturally aligned byte, halfword and word lanes map onto one access.
  function automatic be_dec_t be_decode(input logic [3:0] be);
    be_dec_t d;
    case (be)
      4'b0001: d = '{size: SIZE_BYTE, lsb: 2'd0, illegal: 1'b0};
      4'b0010: d = '{size: SIZE_BYTE, lsb: 2'd1, illegal: 1'b0};
      4'b0100: d = '{size: SIZE_BYTE, lsb: 2'd2, illegal: 1'b0};
      4'b1000: d = '{size: SIZE_BYTE, lsb: 2'd3, illegal: 1'b0};
      4'b0011: d = '{size: SIZE_HALF, lsb: 2'd0, illegal: 1'b0};
      4'b1100: d = '{size: SIZE_HALF, lsb: 2'd2, illegal: 1'b0};
      4'b1111: d = '{size: SIZE_WORD, lsb: 2'd0, illegal: 1'b0};
      default: d = '{size: SIZE_WORD, lsb: 2'd0, illegal: 1'b1};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/data_bus_if.sv
// DATA_BUS: request/response data bus with a slave configuration record.
interface DATA_BUS;
  import data_bus_pkg::*;

  logic        req;
  logic        gnt;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  db_conf_t    conf;

  modport Slave  (input req, we, addr, wdata, be, output gnt, rdata, rvalid, err, conf);
  modport Master (output req, we, addr, wdata, be, input gnt, rdata, rvalid, err, conf);
endinterface

// File: rtl/db_req_fifo.sv
// db_req_fifo: DEPTH-entry request queue with wrapping pointers and an
// occupancy count; the head entry is presented on dout.
module db_req_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  T                r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  // Store the pushed entry; storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wptr] <= din;
    end
  end

  // Advance pointers modulo DEPTH and track occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      end
      if (pop) begin
        r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rptr];
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == CW'(0));
  assign count = r_count;

endmodule

// File: rtl/mem2db_pipe.sv
// mem2db_pipe: bridges a DATA_BUS slave port onto a simple memory request
// interface through an in-order request queue.
// Optional feature: define MEM2DB_TIMEOUT_EN to force-complete a head access
// with an error after TIMEOUT_CYC cycles without ready.
module mem2db_pipe
  import data_bus_pkg::*;
#(
  parameter base_addr_type base_addr   = CFG_BADR_MEM,
  parameter addr_mask_type addr_mask   = CFG_MADR_MEM,
  parameter int            DEPTH       = 2,
  parameter int            TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fault,
  output logic [31:0] wdata,
  output logic [31:0] addr,
  output logic [1:0]  size,
  output logic        ren,
  output logic        wen,
  input  logic [31:0] rdata,
  input  logic        ready,
  DATA_BUS.Slave      dslv
);

  localparam int CW = $clog2(DEPTH) + 1;

  head_st_e      r_state;
  be_dec_t       w_dec;
  db_req_t       w_push_ent;
  db_req_t       w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_gnt;
  logic          w_head_vld;
  logic          w_legal_head;
  logic          w_timeout;
  logic          w_issue;
  logic          w_done_ok;
  logic          w_done_bad;
  logic          w_pop;
  logic          w_unused_addr_lsb;

  // Grant depends only on the registered count, never on ready.
  assign w_gnt = rst_n & dslv.req & ~w_full;

  // Build the queue entry from the bus request and its byte-enable decode.
  always_comb begin
    w_dec      = be_decode(dslv.be);
    w_push_ent = '{addr: dslv.addr, we: dslv.we, wdata: dslv.wdata,
                   size: w_dec.size, lsb: w_dec.lsb, illegal: w_dec.illegal};
  end

  db_req_fifo #(
    .DEPTH (DEPTH),
    .T     (db_req_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_gnt),
    .din   (w_push_ent),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Head FSM: BUSY whenever the queue will hold at least one entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= w_gnt ? ST_BUSY : ST_IDLE;
        ST_BUSY: r_state <= (w_pop && !w_gnt && w_count == CW'(1)) ? ST_IDLE : ST_BUSY;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_head_vld   = (r_state == ST_BUSY) & ~w_empty;
  assign w_legal_head = w_head_vld & ~w_head.illegal;

`ifdef MEM2DB_TIMEOUT_EN
  logic [15:0] r_wait_cnt;

  // Count wait states of the issued head; cleared whenever the head leaves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= 16'd0;
    end else if (w_pop) begin
      r_wait_cnt <= 16'd0;
    end else if (w_legal_head) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end

  assign w_timeout = w_legal_head & (r_wait_cnt == 16'(TIMEOUT_CYC));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_issue    = w_legal_head & ~w_timeout;
  assign w_done_ok  = w_issue & ready;
  assign w_done_bad = (w_head_vld & w_head.illegal) | w_timeout;
  assign w_pop      = w_done_ok | w_done_bad;

  // Lane position comes from be, so the bus address low bits are not used.
  assign w_unused_addr_lsb = ^w_head.addr[1:0];

  // Memory request lines: head entry while occupied, idle values otherwise.
  always_comb begin
    if (w_head_vld) begin
      addr  = {w_head.addr[31:2], w_head.lsb};
      size  = w_head.size;
      wdata = w_head.wdata;
    end else begin
      addr  = 32'd0;
      size  = SIZE_WORD;
      wdata = 32'd0;
    end
    ren = w_issue & ~w_head.we;
    wen = w_issue & w_head.we;
  end

  // Response: at most one per cycle, suppressed while reset is asserted.
  always_comb begin
    dslv.rvalid = rst_n & w_pop;
    dslv.err    = rst_n & (w_done_bad | (w_done_ok & fault));
    if (rst_n && w_done_ok && !w_head.we) begin
      dslv.rdata = rdata;
    end else begin
      dslv.rdata = 32'd0;
    end
  end

  assign dslv.gnt  = w_gnt;
  assign dslv.conf = '{base_addr: base_addr, addr_mask: addr_mask};

endmodule

// File: doc/mem2db_pipe.md
MEM2DB_PIPE -- requirements
Module: mem2db_pipe

Interface
REQ-001 SHALL have parameter base_addr, base_addr_type, default CFG_BADR_MEM: slave base address reported on dslv.conf.base_addr.
REQ-002 SHALL have parameter addr_mask, addr_mask_type, default CFG_MADR_MEM: slave address mask reported on dslv.conf.addr_mask.
REQ-003 SHALL have parameter DEPTH, int, default 2: request queue entries; power of two, at least 1.
REQ-004 SHALL have parameter TIMEOUT_CYC, int, default 255: wait-state limit per access, range 1..65535.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port fault, input, 1 bit: memory fault, sampled on the completion cycle.
REQ-008 SHALL have ports wdata, output, 32 bits; addr, output, 32 bits; size, output, 2 bits; ren, output, 1 bit; wen, output, 1 bit: memory request lines.
REQ-009 SHALL have ports rdata, input, 32 bits and ready, input, 1 bit: memory read data and completion strobe.
REQ-010 SHALL have port dslv, DATA_BUS.Slave: req/gnt/we/addr/wdata/be in; rdata/rvalid/err/conf out.

Function
REQ-011 SHALL assert dslv.gnt combinationally when dslv.req=1 and the registered queue count < DEPTH; no combinational path from ready to gnt.
REQ-012 SHALL push {addr, we, wdata, size, lsb, illegal} on every granted cycle; first memory issue no earlier than the next cycle.
REQ-013 SHALL decode be to size/lsb: 0001/0010/0100/1000 -> size 00, lsb 0/1/2/3; 0011/1100 -> size 01, lsb 0/2; 1111 -> size 10, lsb 0; all other codes -> illegal=1.
REQ-014 SHALL drive addr = {entry.addr[31:2], lsb}, size, wdata, ren=~we, wen=we from the queue head while the queue is non-empty; these lines SHALL stay stable until completion.
REQ-015 SHALL drive ren=wen=0, addr=0, wdata=0, size=10 while the queue is empty.
REQ-016 SHALL complete a legal head access on the cycle ready=1: dslv.rvalid=1, dslv.rdata=rdata for reads, rdata=0 for writes, dslv.err=fault; pop the head the same cycle.
REQ-017 SHALL complete an illegal head entry in one cycle without memory access: ren=wen=0, rvalid=1, err=1, rdata=0, pop.
REQ-018 SHALL return responses in strict request order; at most one rvalid per cycle.
REQ-019 SHALL allow a push and a pop in the same cycle; count unchanged; gnt still gated by the pre-pop count.
REQ-020 SHALL use a two-state head FSM: IDLE (queue empty) -> BUSY on a non-empty count; BUSY -> IDLE on a pop leaving the queue empty; BUSY -> BUSY otherwise.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; count width $clog2(DEPTH)+1.

Reset
REQ-022 SHALL, with rst_n=0 at a rising edge: empty the queue, zero the pointers and wait counter, state=IDLE; outputs then take REQ-015 values with gnt=0, rvalid=0, err=0.
REQ-023 SHALL discard in-flight and queued requests on reset mid-operation, with no rvalid for them afterwards.

Configuration
REQ-024 SHALL, with MEM2DB_TIMEOUT_EN defined, count cycles the head is issued with ready=0; when the count reaches TIMEOUT_CYC, force completion with rvalid=1, err=1, rdata=0, ren=wen=0, pop, and clear the counter.
REQ-025 SHALL, without MEM2DB_TIMEOUT_EN, omit the counter and wait on ready indefinitely.

Structure
REQ-026 SHALL place the size encodings (BYTE=00, HALF=01, WORD=10), the be-decode function and the queue-entry struct in data_bus_pkg.
REQ-027 SHALL implement the queue as sub-module db_req_fifo (parameters DEPTH and entry type; push/pop/full/empty/count).

Verification
REQ-028 Verification SHALL cover a single read: be=1111, addr=0x100, ready=1 one cycle after ren -> size=10, addr=0x100, rvalid with rdata=0xDEADBEEF, err=0.
REQ-029 Verification SHALL cover a byte write: be=0100, addr=0x200, wdata=0x00AA0000 -> wen=1, addr=0x202, size=00; rvalid=1 on ready.
REQ-030 Verification SHALL cover back-pressure: DEPTH=2, ready=0 held, 3 back-to-back reqs -> gnt for the first two only; the third is granted the cycle after the first completion; responses arrive in order.
REQ-031 Verification SHALL cover an illegal be: be=0101 -> no ren/wen, rvalid=1, err=1 one cycle after reaching the head.
REQ-032 Verification SHALL cover timeout: MEM2DB_TIMEOUT_EN defined, TIMEOUT_CYC=4, ready stuck 0 -> rvalid=1, err=1 exactly 4 cycles after ren first rises; the next request is then issued.
REQ-033 Verification SHALL cover reset mid-access: rst_n=0 while BUSY with 2 queued -> outputs at reset values next cycle; no stray rvalid after release.
